// File: rtl/route_rr_nxm.sv
// Round-robin router from NUM_IN tagged input ports into NUM_OUT output FIFOs, with occupancy-based pause.
// Define ROUTE_NXM_STATS_EN to add saturating per-FIFO accepted-word counters on word_count.
module route_rr_nxm #(
    parameter int NUM_IN     = 2,
    parameter int NUM_OUT    = 2,
    parameter int DATA_W     = 8,
    parameter int DEST_W     = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_TH      = 6,
    parameter int AE_TH      = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_IN*(DEST_W+DATA_W)-1:0] in_data,
    input  logic [NUM_IN-1:0]                in_valid,
    output logic [NUM_IN-1:0]                in_ready,
    input  logic [NUM_OUT-1:0]               read,
    output logic [NUM_OUT*DATA_W-1:0]        out_data,
    output logic [NUM_OUT-1:0]               out_valid,
    output logic [NUM_OUT-1:0]               fifo_empty,
    output logic [NUM_OUT-1:0]               fifo_full,
    output logic [NUM_OUT-1:0]               almost_full,
    output logic [NUM_OUT-1:0]               almost_empty,
    output logic [NUM_OUT-1:0]               fifo_pause,
    output logic [NUM_OUT-1:0]               fifo_error,
    output logic                             bad_dest,
    output logic [NUM_OUT*16-1:0]            word_count
);
    localparam int WORD_W    = DEST_W + DATA_W;
    localparam int RR_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int DEST_SPAN = 1 << DEST_W;

    logic [RR_W-1:0]      rr;
    logic [RR_W-1:0]      grant_idx;
    logic                 grant_found;
    logic [NUM_IN-1:0]    eligible;
    logic [DEST_SPAN-1:0] pause_by_dest;
    logic [WORD_W-1:0]    grant_word;
    logic                 stage_valid;
    logic [DEST_W-1:0]    stage_dest;
    logic [DATA_W-1:0]    stage_data;
    int                   arb_idx;

    // Out-of-range destinations never pause, so bad words are always drained and flagged.
    always_comb begin
        pause_by_dest = '0;
        pause_by_dest[NUM_OUT-1:0] = fifo_pause;
    end

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_IN; i++)
            eligible[i] = in_valid[i] && !pause_by_dest[in_data[i*WORD_W+DATA_W +: DEST_W]];
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr;
        arb_idx     = 0;
        for (int k = 1; k <= NUM_IN; k++) begin
            arb_idx = (int'(rr) + k) % NUM_IN;
            if (!grant_found && eligible[arb_idx]) begin
                grant_found = 1'b1;
                grant_idx   = RR_W'(arb_idx);
            end
        end
        if (reset)
            grant_found = 1'b0;
    end

    assign in_ready   = grant_found ? (NUM_IN'(1) << grant_idx) : '0;
    assign grant_word = in_data[int'(grant_idx)*WORD_W +: WORD_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            rr          <= RR_W'(NUM_IN - 1);
            stage_valid <= 1'b0;
            stage_dest  <= '0;
            stage_data  <= '0;
            bad_dest    <= 1'b0;
        end else begin
            stage_valid <= grant_found;
            if (grant_found) begin
                rr         <= grant_idx;
                stage_dest <= grant_word[WORD_W-1 -: DEST_W];
                stage_data <= grant_word[DATA_W-1:0];
            end
            if (stage_valid && (int'(stage_dest) >= NUM_OUT))
                bad_dest <= 1'b1;
        end
    end

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_fifo
        logic [DATA_W-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  count;
        logic [DATA_W-1:0] head_q;
        logic              valid_q;
        logic              error_q;
        logic              wr_req;
        logic              pop;
        logic              do_wr;
        logic              is_full;

        assign is_full = (count == CNT_W'(FIFO_DEPTH));
        assign wr_req  = stage_valid && (stage_dest == DEST_W'(j));
        assign pop     = read[j] && (count != '0);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
        assign do_wr   = wr_req && (!is_full || pop);

        always_ff @(posedge clk) begin
            if (do_wr)
                mem[wr_ptr] <= stage_data;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                head_q  <= '0;
                valid_q <= 1'b0;
                error_q <= 1'b0;
            end else begin
                valid_q <= pop;
                if (do_wr)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    head_q <= mem[rd_ptr];
                end
                if (do_wr && !pop)
                    count <= count + 1'b1;
                else if (pop && !do_wr)
                    count <= count - 1'b1;
                if ((read[j] && (count == '0)) || (wr_req && !do_wr))
                    error_q <= 1'b1;
            end
        end

        assign out_data[j*DATA_W +: DATA_W] = head_q;
        assign out_valid[j]    = valid_q;
        assign fifo_error[j]   = error_q;
        assign fifo_empty[j]   = (count == '0);
        assign fifo_full[j]    = is_full;
        assign almost_full[j]  = int'(count) >= AF_TH;
        assign almost_empty[j] = int'(count) <= AE_TH;
        assign fifo_pause[j]   = (int'(count) + (wr_req ? 1 : 0)) >= AF_TH;

`ifdef ROUTE_NXM_STATS_EN
        logic [15:0] words_q;

        always_ff @(posedge clk) begin
            if (reset)
                words_q <= '0;
            else if (do_wr && (words_q != 16'hFFFF))
                words_q <= words_q + 16'd1;
        end

        assign word_count[j*16 +: 16] = words_q;
`else
        assign word_count[j*16 +: 16] = 16'h0000;
`endif
    end

endmodule

// File: tb/tb_route_rr_nxm.sv
// Self-checking bench for route_rr_nxm: directed scenarios plus randomized traffic against a queue-based model.
module tb_route_rr_nxm;
    localparam int NUM_IN     = 2;
    localparam int NUM_OUT    = 3;
    localparam int DATA_W     = 8;
    localparam int DEST_W     = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int AF_TH      = 6;
    localparam int AE_TH      = 2;
    localparam int WORD_W     = DEST_W + DATA_W;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NUM_IN*WORD_W-1:0]    in_data;
    logic [NUM_IN-1:0]           in_valid;
    logic [NUM_IN-1:0]           in_ready;
    logic [NUM_OUT-1:0]          read;
    logic [NUM_OUT*DATA_W-1:0]   out_data;
    logic [NUM_OUT-1:0]          out_valid;
    logic [NUM_OUT-1:0]          fifo_empty;
    logic [NUM_OUT-1:0]          fifo_full;
    logic [NUM_OUT-1:0]          almost_full;
    logic [NUM_OUT-1:0]          almost_empty;
    logic [NUM_OUT-1:0]          fifo_pause;
    logic [NUM_OUT-1:0]          fifo_error;
    logic                        bad_dest;
    logic [NUM_OUT*16-1:0]       word_count;

    int vectors = 0;
    int errors  = 0;

    route_rr_nxm #(
        .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .DEST_W(DEST_W),
        .FIFO_DEPTH(FIFO_DEPTH), .AF_TH(AF_TH), .AE_TH(AE_TH)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .read(read), .out_data(out_data), .out_valid(out_valid), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .almost_full(almost_full), .almost_empty(almost_empty),
        .fifo_pause(fifo_pause), .fifo_error(fifo_error), .bad_dest(bad_dest), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per output FIFO plus the single staged word.
    int q [NUM_OUT][$];
    int m_rr;
    bit m_sv;
    int m_sd;
    int m_sdata;
    bit m_bad;
    bit [NUM_OUT-1:0] m_err;
    bit [NUM_OUT-1:0] m_ov;
    int m_od [NUM_OUT];
    int m_wc [NUM_OUT];

    function automatic int port_dest(int p);
        return int'(in_data[p*WORD_W+DATA_W +: DEST_W]);
    endfunction

    function automatic int port_payload(int p);
        return int'(in_data[p*WORD_W +: DATA_W]);
    endfunction

    function automatic int m_occ(int j);
        return q[j].size() + ((m_sv && m_sd == j) ? 1 : 0);
    endfunction

    function automatic int m_grant();
        int p, d;
        if (reset) return -1;
        for (int k = 1; k <= NUM_IN; k++) begin
            p = (m_rr + k) % NUM_IN;
            if (in_valid[p]) begin
                d = port_dest(p);
                if (d >= NUM_OUT || m_occ(d) < AF_TH) return p;
            end
        end
        return -1;
    endfunction

    function automatic logic [NUM_IN-1:0] exp_ready();
        int g;
        logic [NUM_IN-1:0] r;
        g = m_grant();
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // kind: 0 empty, 1 full, 2 almost_full, 3 almost_empty, 4 pause
    function automatic logic [NUM_OUT-1:0] exp_status(int kind);
        logic [NUM_OUT-1:0] r;
        int n;
        r = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            n = q[j].size();
            case (kind)
                0: r[j] = (n == 0);
                1: r[j] = (n == FIFO_DEPTH);
                2: r[j] = (n >= AF_TH);
                3: r[j] = (n <= AE_TH);
                default: r[j] = (m_occ(j) >= AF_TH);
            endcase
        end
        return r;
    endfunction

    function automatic logic [NUM_OUT*DATA_W-1:0] exp_out_data();
        logic [NUM_OUT*DATA_W-1:0] r;
        for (int j = 0; j < NUM_OUT; j++) r[j*DATA_W +: DATA_W] = DATA_W'(m_od[j]);
        return r;
    endfunction

    function automatic logic [NUM_OUT*16-1:0] exp_word_count();
        logic [NUM_OUT*16-1:0] r;
        for (int j = 0; j < NUM_OUT; j++) r[j*16 +: 16] = 16'(m_wc[j]);
        return r;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < NUM_OUT; j++) begin
            q[j].delete();
            m_od[j] = 0;
            m_wc[j] = 0;
        end
        m_rr = NUM_IN - 1;
        m_sv = 0;
        m_sd = 0;
        m_sdata = 0;
        m_bad = 0;
        m_err = '0;
        m_ov = '0;
    endtask

    task automatic model_clock();
        int g;
        g = m_grant();
        if (reset) begin
            model_reset();
            return;
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            m_ov[j] = 0;
            if (read[j]) begin
                if (q[j].size() > 0) begin
                    m_od[j] = q[j].pop_front();
                    m_ov[j] = 1;
                end else begin
                    m_err[j] = 1;
                end
            end
        end
        if (m_sv) begin
            if (m_sd >= NUM_OUT) m_bad = 1;
            else if (q[m_sd].size() >= FIFO_DEPTH) m_err[m_sd] = 1;
            else begin
                q[m_sd].push_back(m_sdata);
`ifdef ROUTE_NXM_STATS_EN
                if (m_wc[m_sd] < 65535) m_wc[m_sd]++;
`endif
            end
        end
        if (g >= 0) begin
            m_sv = 1;
            m_sd = port_dest(g);
            m_sdata = port_payload(g);
            m_rr = g;
        end else begin
            m_sv = 0;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic drive_port(int p, bit v, int dest, int data);
        in_valid[p] = v;
        in_data[p*WORD_W +: WORD_W] = {DEST_W'(dest), DATA_W'(data)};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = '0;
        read = '0;
        advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_port(0, 1, 0, 8'h11);
        drive_port(1, 1, 1, 8'h22);
        read = '1;
        advance();
        advance();
        @(negedge clk);
        vectors++; if (in_ready !== '0) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready); end
        vectors++; if (out_valid !== '0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        vectors++; if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data got=%h exp=0", out_data); end
        vectors++; if (fifo_empty !== '1) begin errors++; $display("[TB] FAIL reset_empty got=%b exp=111", fifo_empty); end
        vectors++; if (almost_empty !== '1) begin errors++; $display("[TB] FAIL reset_almost_empty got=%b exp=111", almost_empty); end
        vectors++; if ({fifo_full, almost_full, fifo_pause, fifo_error} !== '0) begin
            errors++; $display("[TB] FAIL reset_flags got full=%b af=%b pause=%b err=%b exp all 0", fifo_full, almost_full, fifo_pause, fifo_error);
        end
        vectors++; if (bad_dest !== 1'b0) begin errors++; $display("[TB] FAIL reset_bad_dest got=%b exp=0", bad_dest); end
        vectors++; if (word_count !== '0) begin errors++; $display("[TB] FAIL reset_word_count got=%h exp=0", word_count); end
        in_valid = '0;
        read = '0;
        advance();
        reset = 1'b0;
    endtask

    task automatic test_fairness();
        logic [NUM_IN-1:0] exp;
        do_reset();
        read = '1;
        for (int c = 0; c < 10; c++) begin
            drive_port(0, 1, 0, c);
            drive_port(1, 1, 1, 8'h80 + c);
            @(negedge clk);
            exp = (c % 2 == 0) ? 2'b01 : 2'b10;
            vectors++; if (in_ready !== exp) begin errors++; $display("[TB] FAIL fairness_grant cycle %0d got=%b exp=%b", c, in_ready, exp); end
            advance();
        end
        in_valid = '0;
        read = '0;
    endtask

    task automatic test_backpressure();
        int accepted;
        bit dropped;
        do_reset();
        accepted = 0;
        dropped = 0;
        for (int c = 0; c < 20 && !dropped; c++) begin
            drive_port(0, 1, 0, c);
            @(negedge clk);
            if (in_ready[0]) accepted++;
            else dropped = 1;
            advance();
        end
        vectors++; if (!dropped) begin errors++; $display("[TB] FAIL bp_ready_drop got=never exp=drop after 6"); end
        vectors++; if (accepted !== 6) begin errors++; $display("[TB] FAIL bp_accepted got=%0d exp=6", accepted); end
        advance();
        @(negedge clk);
        vectors++; if (in_ready[0] !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_held got=%b exp=0", in_ready[0]); end
        vectors++; if (almost_full[0] !== 1'b1) begin errors++; $display("[TB] FAIL bp_almost_full got=%b exp=1", almost_full[0]); end
        vectors++; if (fifo_pause[0] !== 1'b1) begin errors++; $display("[TB] FAIL bp_pause got=%b exp=1", fifo_pause[0]); end
        vectors++; if (fifo_full[0] !== 1'b0) begin errors++; $display("[TB] FAIL bp_full got=%b exp=0", fifo_full[0]); end
        vectors++; if (fifo_error[0] !== 1'b0) begin errors++; $display("[TB] FAIL bp_error got=%b exp=0", fifo_error[0]); end
        vectors++; if (almost_empty[0] !== 1'b0) begin errors++; $display("[TB] FAIL bp_almost_empty got=%b exp=0", almost_empty[0]); end
        in_valid = '0;
    endtask

    task automatic test_order_wrap();
        int sent, got;
        do_reset();
        sent = 0;
        got = 0;
        read = 3'b010;
        drive_port(0, 0, 0, 0);
        drive_port(1, 1, 1, 0);
        for (int c = 0; c < 200 && got < 20; c++) begin
            @(negedge clk);
            if (out_valid[1]) begin
                vectors++;
                if (out_data[DATA_W +: DATA_W] !== DATA_W'(got)) begin
                    errors++; $display("[TB] FAIL order_data idx %0d got=%h exp=%h", got, out_data[DATA_W +: DATA_W], DATA_W'(got));
                end
                got++;
            end
            if (in_ready[1]) sent++;
            advance();
            drive_port(1, sent < 20, 1, sent);
        end
        vectors++; if (got !== 20) begin errors++; $display("[TB] FAIL order_count got=%0d exp=20", got); end
        in_valid = '0;
        read = '0;
    endtask

    task automatic test_empty_read();
        do_reset();
        read = 3'b001;
        advance();
        read = '0;
        @(negedge clk);
        vectors++; if (fifo_error[0] !== 1'b1) begin errors++; $display("[TB] FAIL empty_read_error got=%b exp=1", fifo_error[0]); end
        vectors++; if (out_valid[0] !== 1'b0) begin errors++; $display("[TB] FAIL empty_read_valid got=%b exp=0", out_valid[0]); end
        vectors++; if (fifo_error[1] !== 1'b0 || fifo_empty[1] !== 1'b1) begin
            errors++; $display("[TB] FAIL empty_read_other got err=%b empty=%b exp err=0 empty=1", fifo_error[1], fifo_empty[1]);
        end
        advance();
        @(negedge clk);
        vectors++; if (fifo_error[0] !== 1'b1) begin errors++; $display("[TB] FAIL empty_read_sticky got=%b exp=1", fifo_error[0]); end
    endtask

    task automatic test_bad_dest();
        do_reset();
        drive_port(0, 1, 3, 8'hAA);
        @(negedge clk);
        vectors++; if (in_ready !== 2'b01) begin errors++; $display("[TB] FAIL bad_dest_ready got=%b exp=01", in_ready); end
        advance();
        in_valid = '0;
        advance();
        @(negedge clk);
        vectors++; if (bad_dest !== 1'b1) begin errors++; $display("[TB] FAIL bad_dest_flag got=%b exp=1", bad_dest); end
        vectors++; if (fifo_empty !== '1) begin errors++; $display("[TB] FAIL bad_dest_counts got empty=%b exp=111", fifo_empty); end
        vectors++; if (word_count !== '0) begin errors++; $display("[TB] FAIL bad_dest_word_count got=%h exp=0", word_count); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive_port(0, 1, 0, 8'h40 + c);
            advance();
        end
        @(negedge clk);
        vectors++; if (fifo_empty[0] !== 1'b0 || almost_empty[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_preload got empty=%b ae=%b exp 0 0", fifo_empty[0], almost_empty[0]);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (in_ready !== '0) begin errors++; $display("[TB] FAIL midreset_ready got=%b exp=0", in_ready); end
        advance();
        reset = 1'b0;
        in_valid = '0;
        @(negedge clk);
        vectors++; if (fifo_empty !== '1 || almost_empty !== '1) begin
            errors++; $display("[TB] FAIL midreset_empty got empty=%b ae=%b exp 111 111", fifo_empty, almost_empty);
        end
        vectors++; if ({out_valid, fifo_pause, almost_full, fifo_error, bad_dest} !== '0) begin
            errors++; $display("[TB] FAIL midreset_flags got ov=%b pause=%b af=%b err=%b bad=%b exp all 0", out_valid, fifo_pause, almost_full, fifo_error, bad_dest);
        end
        vectors++; if (word_count !== '0) begin errors++; $display("[TB] FAIL midreset_word_count got=%h exp=0", word_count); end
        advance();
        @(negedge clk);
        vectors++; if (fifo_empty !== '1 || out_valid !== '0) begin
            errors++; $display("[TB] FAIL midreset_stage_lost got empty=%b ov=%b exp 111 000", fifo_empty, out_valid);
        end
    endtask

    task automatic test_random();
        int rd_pct;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rd_pct = (c < 200) ? 25 : 75;
            reset = ($urandom_range(0, 99) == 0);
            for (int p = 0; p < NUM_IN; p++)
                drive_port(p, $urandom_range(0, 3) != 0,
                           ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, NUM_OUT - 1),
                           $urandom_range(0, 255));
            for (int j = 0; j < NUM_OUT; j++) read[j] = ($urandom_range(0, 99) < rd_pct);
            @(negedge clk);
            vectors++; if (in_ready !== exp_ready()) begin errors++; $display("[TB] FAIL rnd_in_ready cyc %0d got=%b exp=%b", c, in_ready, exp_ready()); end
            vectors++; if (out_valid !== m_ov) begin errors++; $display("[TB] FAIL rnd_out_valid cyc %0d got=%b exp=%b", c, out_valid, m_ov); end
            vectors++; if (out_data !== exp_out_data()) begin errors++; $display("[TB] FAIL rnd_out_data cyc %0d got=%h exp=%h", c, out_data, exp_out_data()); end
            vectors++; if (fifo_empty !== exp_status(0)) begin errors++; $display("[TB] FAIL rnd_empty cyc %0d got=%b exp=%b", c, fifo_empty, exp_status(0)); end
            vectors++; if (fifo_full !== exp_status(1)) begin errors++; $display("[TB] FAIL rnd_full cyc %0d got=%b exp=%b", c, fifo_full, exp_status(1)); end
            vectors++; if (almost_full !== exp_status(2)) begin errors++; $display("[TB] FAIL rnd_almost_full cyc %0d got=%b exp=%b", c, almost_full, exp_status(2)); end
            vectors++; if (almost_empty !== exp_status(3)) begin errors++; $display("[TB] FAIL rnd_almost_empty cyc %0d got=%b exp=%b", c, almost_empty, exp_status(3)); end
            vectors++; if (fifo_pause !== exp_status(4)) begin errors++; $display("[TB] FAIL rnd_pause cyc %0d got=%b exp=%b", c, fifo_pause, exp_status(4)); end
            vectors++; if (fifo_error !== m_err) begin errors++; $display("[TB] FAIL rnd_error cyc %0d got=%b exp=%b", c, fifo_error, m_err); end
            vectors++; if (bad_dest !== m_bad) begin errors++; $display("[TB] FAIL rnd_bad_dest cyc %0d got=%b exp=%b", c, bad_dest, m_bad); end
            vectors++; if (word_count !== exp_word_count()) begin errors++; $display("[TB] FAIL rnd_word_count cyc %0d got=%h exp=%h", c, word_count, exp_word_count()); end
            advance();
        end
        reset = 1'b0;
        in_valid = '0;
        read = '0;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = '0;
        in_data = '0;
        read = '0;
        model_reset();
        $display("[TB] starting route_rr_nxm bench");
        test_reset();
        test_fairness();
        test_backpressure();
        test_order_wrap();
        test_empty_read();
        test_bad_dest();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/route_rr_nxm.md
# route_rr_nxm

Parametrised successor of the two-input routing block. It accepts tagged words from NUM_IN input ports and arbitrates among them round-robin, one word per cycle. Each word is steered by its destination field into one of NUM_OUT output FIFOs, with credit-style backpressure that makes FIFO overflow impossible by construction. It sits between the link-layer input stage and the per-lane consumers of the PCIe switching fabric.

## Interface
- NUM_IN, 2, number of input ports (2..8)
- NUM_OUT, 2, number of output FIFOs (2..8)
- DATA_W, 8, payload bits per word
- DEST_W, 2, destination field bits; must satisfy 2^DEST_W >= NUM_OUT
- FIFO_DEPTH, 8, entries per output FIFO (power of two, 4..64)
- AF_TH, 6, almost-full/pause threshold (2..FIFO_DEPTH)
- AE_TH, 2, almost-empty threshold (1..FIFO_DEPTH-1)
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_data  in  NUM_IN*(DEST_W+DATA_W)  port i at slice i; word = {dest, payload}
- in_valid  in  NUM_IN  word present on port i
- in_ready  out  NUM_IN  port i word accepted this cycle (combinational)
- read  in  NUM_OUT  pop request per FIFO
- out_data  out  NUM_OUT*DATA_W  popped payload, registered
- out_valid  out  NUM_OUT  out_data slice j valid this cycle
- fifo_empty, fifo_full, almost_full, almost_empty, fifo_pause, fifo_error  out  NUM_OUT each  per-FIFO status
- bad_dest  out  1  sticky: a word with dest >= NUM_OUT was accepted and dropped
- word_count  out  NUM_OUT*16  per-FIFO accepted-word counters (see Configuration)

## Operation
- Occupancy occ[j] = count[j] + (stage_valid && stage_dest == j).
- fifo_pause[j] = occ[j] >= AF_TH. almost_full[j] = count[j] >= AF_TH. almost_empty[j] = count[j] <= AE_TH. fifo_empty[j] = count[j] == 0. fifo_full[j] = count[j] == FIFO_DEPTH.
- Eligible input i: in_valid[i], and either its dest >= NUM_OUT or fifo_pause[dest] is 0.
- Arbiter: a round-robin pointer rr holds the last granted port. The search starts at rr+1 modulo NUM_IN, and the first eligible port is granted. in_ready is one-hot or zero. rr updates only on a grant.
- Granted word is loaded into a single stage register (stage_valid, stage_dest, stage_data).
  - Next cycle, if the destination is valid, the stage writes FIFO[stage_dest].
  - If dest >= NUM_OUT, the word is discarded and bad_dest is set.
- Read: read[j] with count[j] > 0 pops the head into out_data slice j, and out_valid[j] is 1 next cycle.
- Read with count 0: no pop, out_valid[j] = 0, out_data holds, and fifo_error[j] is set (sticky).
- A write when full sets fifo_error[j] and drops the word. This is unreachable while AF_TH <= FIFO_DEPTH and is kept as a checker.
- Simultaneous write and read on one FIFO: both happen, count unchanged. This is legal when full, since the read frees the slot first.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.

## Timing
- Latency from in_valid&&in_ready at cycle t: the word is in the FIFO at t+1, and count is visible at t+2.
- Minimum in-to-out: read asserted at t+2 gives out_valid at t+3.
- Throughput: one word per cycle aggregate, one pop per FIFO per cycle.
- Reset values (in effect the cycle after reset is sampled high):
  - out_data = 0, out_valid = 0, in_ready = 0 while reset is high.
  - fifo_empty = 1, almost_empty = 1.
  - fifo_full, almost_full, fifo_pause, fifo_error, bad_dest = 0.
  - word_count = 0, rr = NUM_IN-1 (port 0 has first priority), stage_valid = 0.
- Reset mid-operation: FIFO contents and the stage word are lost, and all state returns to the values above. No partial word is output.

## Configuration
- ROUTE_NXM_STATS_EN defined: word_count[j] increments on every write into FIFO j and saturates at 16'hFFFF.
- ROUTE_NXM_STATS_EN undefined: word_count is tied to 0 and no counter flops are generated.

## Test plan
- Arbitration fairness: NUM_IN=2, both ports valid continuously, dest=0 and dest=1, FIFOs drained every cycle. Grants must alternate 0,1,0,1…, with port 0 granted first after reset.
- Backpressure: port 0 streams dest=0 with read0=0.
  - After 6 accepted words, in_ready[0] drops.
  - count0 reaches 6, almost_full0=1, fifo_pause0=1, fifo_full0=0, no fifo_error.
- Ordering and wrap: push 20 words with payloads 0x00..0x13 to FIFO 1 while reading continuously. out_data1 must return 0x00..0x13 in order, with the pointers having wrapped twice.
- Empty read: read0=1 on an empty FIFO 0. fifo_error0=1 next cycle and stays set, out_valid0=0, and FIFO 1 is unaffected.
- Bad destination: NUM_OUT=3, DEST_W=2, send dest=3 payload 0xAA. in_ready=1, bad_dest=1, and no FIFO count changes.
- Reset mid-stream: assert reset with 4 words in FIFO 0 and the stage valid. Next cycle all outputs are at reset values. With ROUTE_NXM_STATS_EN, word_count returns to 0.
